// File: rtl/mem_port_arbiter.sv
//============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one unified memory port between the CPU (requester 0)
//            and the DMA/debug loader (requester 1). Latches the winning
//            request for the whole access, returns one-cycle acks and
//            aborts accesses that run past a wait-state timeout.
// Config   : MEM_ARB_RR_EN defined   -> round-robin arbitration
//            MEM_ARB_RR_EN undefined -> fixed CPU priority with DMA
//                                       starvation counter
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_WAIT     = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  // CPU requester
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_ack,
  // DMA requester
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wd,
  output logic [DW-1:0] dma_rd,
  output logic          dma_ack,
  // Memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  input  logic          mem_ready,
  // Status
  output logic          owner,
  output logic          busy,
  output logic          timeout_err
);

  // wait_cnt only needs to reach MAX_WAIT-1: the abort fires on that cycle.
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              grant_dma;
  logic              wait_expired;

  assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

`ifdef MEM_ARB_RR_EN
  logic last_owner;

  // Contention goes to whichever requester did not win last time.
  always_comb grant_dma = dma_req && (!cpu_req || !last_owner);

  // Remember the most recent grant; reset value 1 lets the CPU win first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= 1'b1;
    end else if (state == IDLE && (cpu_req || dma_req)) begin
      last_owner <= grant_dma;
    end
  end
`else
  localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [STARVE_W-1:0] starve_cnt;

  // CPU wins contention unless the DMA has been passed over STARVE_LIMIT times.
  always_comb grant_dma = dma_req && (!cpu_req || (starve_cnt == STARVE_W'(STARVE_LIMIT)));

  // Count CPU grants taken while the DMA was waiting; clear on DMA grant or idle DMA.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!dma_req || grant_dma) begin
        starve_cnt <= '0;
      end else if (cpu_req && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end
`endif

  // Main access FSM; every output is registered so the memory sees stable values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      owner       <= 1'b0;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_adr     <= '0;
      mem_wd      <= '0;
      cpu_rd      <= '0;
      dma_rd      <= '0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Acks and the timeout flag are single-cycle pulses.
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            state    <= ACCESS;
            owner    <= grant_dma;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
            mem_we   <= grant_dma ? dma_we  : cpu_we;
            mem_adr  <= grant_dma ? dma_adr : cpu_adr;
            mem_wd   <= grant_dma ? dma_wd  : cpu_wd;
          end
        end

        ACCESS: begin
          if (mem_ready || wait_expired) begin
            // A ready on the last allowed cycle still counts as a completion.
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_ready) begin
              timeout_err <= 1'b1;
            end
            if (owner) begin
              dma_rd  <= mem_ready ? mem_rd : '0;
              dma_ack <= 1'b1;
            end else begin
              cpu_rd  <= mem_ready ? mem_rd : '0;
              cpu_ack <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        RESP: begin
          // Requests are ignored here so the finishing requester cannot be re-granted.
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter with an ack
//            scoreboard. Define MEM_ARB_RR_EN to check the round-robin build.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int MAX_WAIT     = 15;
    localparam int STARVE_LIMIT = 4;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wd, cpu_rd;
    logic          dma_req, dma_we, dma_ack;
    logic [AW-1:0] dma_adr;
    logic [DW-1:0] dma_wd, dma_rd;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          owner, busy, timeout_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          who;
        logic [31:0] rd;
        bit          to;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_cpu_rd;
    logic [31:0] m_dma_rd;
    bit          m_last;
    int          m_starve;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
        .dma_rd(dma_rd), .dma_ack(dma_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .mem_ready(mem_ready),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_ack === 1'b1 || dma_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_ack observed=%0h expected=0", {cpu_ack, dma_ack});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if ((e.who ? dma_ack : cpu_ack) !== 1'b1) begin
                    bad++;
                    $error("FAIL sb_own_ack observed=%0h expected=1", e.who ? dma_ack : cpu_ack);
                end
                total++;
                if ((e.who ? cpu_ack : dma_ack) !== 1'b0) begin
                    bad++;
                    $error("FAIL sb_other_ack observed=%0h expected=0", e.who ? cpu_ack : dma_ack);
                end
                total++;
                if ((e.who ? dma_rd : cpu_rd) !== e.rd) begin
                    bad++;
                    $error("FAIL sb_rd observed=%0h expected=%0h", e.who ? dma_rd : cpu_rd, e.rd);
                end
                total++;
                if (timeout_err !== e.to) begin
                    bad++;
                    $error("FAIL sb_timeout observed=%0h expected=%0h", timeout_err, e.to);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input bit d, input bit we, input logic [31:0] adr,
                            input logic [31:0] wd, input int waits,
                            input logic [31:0] rdat, input bit to, input bit drop);
        exp_t e;
        if (d) begin
            dma_req = 1'b1; dma_we = we; dma_adr = adr; dma_wd = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wd = wd;
        end
        mem_rd    = rdat;
        mem_ready = 1'b0;
        e.who = d; e.rd = to ? 32'h0 : rdat; e.to = to;
        exp_q.push_back(e);
        tick();
        for (int i = 0; i <= waits; i++) begin
            chk("acc_mem_req", mem_req, 1'b1);
            chk("acc_owner", owner, d);
            chk("acc_mem_we", mem_we, we);
            chk("acc_mem_adr", mem_adr, adr);
            chk("acc_mem_wd", mem_wd, wd);
            chk("acc_busy", busy, 1'b1);
            chk("acc_no_ack", {cpu_ack, dma_ack}, 2'b00);
            if (i == 0) begin
                if (d) begin
                    dma_adr = adr ^ 32'hFFFF_0000; dma_wd = ~wd; dma_we = ~we;
                    if (drop) dma_req = 1'b0;
                end else begin
                    cpu_adr = adr ^ 32'hFFFF_0000; cpu_wd = ~wd; cpu_we = ~we;
                    if (drop) cpu_req = 1'b0;
                end
            end
            mem_ready = (i == waits) && !to;
            tick();
        end
        mem_ready = 1'b0;
        chk("resp_mem_req", mem_req, 1'b0);
        chk("resp_busy", busy, 1'b1);
        chk("resp_own_ack", d ? dma_ack : cpu_ack, 1'b1);
        chk("resp_other_ack", d ? cpu_ack : dma_ack, 1'b0);
        chk("resp_timeout_err", timeout_err, to);
        chk("resp_rd", d ? dma_rd : cpu_rd, e.rd);
        if (d) m_dma_rd = e.rd; else m_cpu_rd = e.rd;
        m_last   = d;
        m_starve = 0;
        cpu_req  = 1'b0;
        dma_req  = 1'b0;
        tick();
        chk("idle_acks", {cpu_ack, dma_ack}, 2'b00);
        chk("idle_busy", busy, 1'b0);
        chk("idle_timeout_err", timeout_err, 1'b0);
        chk("idle_cpu_rd", cpu_rd, m_cpu_rd);
        chk("idle_dma_rd", dma_rd, m_dma_rd);
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wd = '0;
        dma_req   = 1'b0; dma_we = 1'b0; dma_adr = '0; dma_wd = '0;
        mem_rd    = '0;   mem_ready = 1'b0;
        m_cpu_rd  = '0;   m_dma_rd = '0;
        m_last    = 1'b1; m_starve = 0;

        tick();
        tick();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_acks", {cpu_ack, dma_ack}, 2'b00);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_cpu_rd", cpu_rd, 32'h0);
        chk("rst_dma_rd", dma_rd, 32'h0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        reset = 1'b0;
        tick();

        run_xfer(1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        run_xfer(1'b1, 1'b1, 32'h0000_0100, 32'h0000_1234, 3, 32'h5555_AAAA, 1'b0, 1'b0);

        run_xfer(1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 2, 32'h0BAD_0001, 1'b0, 1'b1);

        run_xfer(1'b0, 1'b0, 32'h0000_0300, 32'h0, MAX_WAIT - 1, 32'hFFFF_FFFF, 1'b1, 1'b0);

        cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
        cpu_adr = 32'h10; dma_adr = 32'h20; mem_ready = 1'b1;
        for (int g = 0; g < 10; g++) begin
            exp_t e;
            bit   ed;
`ifdef MEM_ARB_RR_EN
            ed = !m_last;
`else
            ed = (m_starve == STARVE_LIMIT);
`endif
            mem_rd = 32'hA500_0000 + 32'(g);
            e.who = ed; e.rd = mem_rd; e.to = 1'b0;
            exp_q.push_back(e);
            tick();
            chk("arb_mem_req", mem_req, 1'b1);
            chk("arb_owner", owner, ed);
            tick();
            tick();
            if (ed) m_dma_rd = e.rd; else m_cpu_rd = e.rd;
            m_last = ed;
            if (ed) m_starve = 0; else m_starve++;
        end
        cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
        tick();
        chk("arb_cpu_rd", cpu_rd, m_cpu_rd);
        chk("arb_dma_rd", dma_rd, m_dma_rd);

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h80; cpu_wd = 32'h77;
        tick();
        chk("mid_mem_req", mem_req, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_mem_req", mem_req, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_acks", {cpu_ack, dma_ack}, 2'b00);
        chk("mid_rst_cpu_rd", cpu_rd, 32'h0);
        chk("mid_rst_dma_rd", dma_rd, 32'h0);
        chk("mid_rst_mem_adr", mem_adr, 32'h0);
        chk("mid_rst_owner", owner, 1'b0);
        reset   = 1'b0;
        cpu_req = 1'b0;
        m_cpu_rd = '0; m_dma_rd = '0; m_last = 1'b1; m_starve = 0;
        tick();
        chk("post_rst_acks", {cpu_ack, dma_ack}, 2'b00);
        chk("post_rst_mem_req", mem_req, 1'b0);

        run_xfer(1'b1, 1'b0, 32'h0000_0400, 32'h0, 1, 32'h1357_9BDF, 1'b0, 1'b0);

        tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
